// File: rtl/add_sub_np.sv
// add_sub_np: N-segment carry-pipelined adder/subtractor.
// Operands are split into STAGES segments of SW bits. One segment is added per
// clock, and the carry ripples forward through a register between segments.
// Operand registers shift right by SW each stage, so the segment being added
// always sits in bits [SW-1:0]. The result register shifts right by SW and
// takes the new segment in at the top. After STAGES adds, the result is in
// natural bit order.
module add_sub_np #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             valid_in,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             valid_out
);

    localparam int SW = WIDTH / STAGES;

    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
        $error("add_sub_np: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
    end

    // One SW+1-bit add: the only arithmetic between any two registers
    function automatic logic [SW:0] seg_add(input logic [SW-1:0] a,
                                            input logic [SW-1:0] b,
                                            input logic          c);
        return {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, c};
    endfunction

    // Operand pipeline: index 0 is the input register; index k holds the
    // operands still waiting to be added after stage k
    logic [WIDTH-1:0] xs_p  [STAGES];
    logic [WIDTH-1:0] ys_p  [STAGES];
    // Partial results: r_p[k] holds the result after stage k+1
    logic [WIDTH-1:0] r_p   [STAGES];
    logic [STAGES:0]  c_p;
    logic [STAGES:0]  vld_p;
    logic             ovf_p;

    logic [SW:0]      seg   [STAGES];
    logic [WIDTH-1:0] r_nxt [STAGES];

    // Segment adds and the next partial-result words
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg[k] = seg_add(xs_p[k][SW-1:0], ys_p[k][SW-1:0], c_p[k]);
        end
        r_nxt[0] = WIDTH'(seg[0][SW-1:0]) << (WIDTH - SW);
        for (int k = 1; k < STAGES; k++) begin
            r_nxt[k] = (WIDTH'(seg[k][SW-1:0]) << (WIDTH - SW)) | (r_p[k-1] >> SW);
        end
    end

    // Every pipeline register: async clear, hold while ena is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                xs_p[k] <= '0;
                ys_p[k] <= '0;
                r_p[k]  <= '0;
            end
            c_p   <= '0;
            vld_p <= '0;
            ovf_p <= 1'b0;
        end else if (ena) begin
            // stage 0: input register; subtract is x + ~y + ~borrow
            xs_p[0]  <= x;
            ys_p[0]  <= sub ? ~y : y;
            c_p[0]   <= sub ^ cin;
            vld_p[0] <= valid_in;
            // stages 1..STAGES: add one segment, shift the rest along
            for (int k = 1; k < STAGES; k++) begin
                xs_p[k] <= xs_p[k-1] >> SW;
                ys_p[k] <= ys_p[k-1] >> SW;
            end
            for (int k = 0; k < STAGES; k++) begin
                r_p[k]     <= r_nxt[k];
                c_p[k+1]   <= seg[k][SW];
                vld_p[k+1] <= vld_p[k];
            end
            // carry into the MSB is recovered from the MSB sum bit
            ovf_p <= seg[STAGES-1][SW] ^ xs_p[STAGES-1][SW-1]
                   ^ ys_p[STAGES-1][SW-1] ^ seg[STAGES-1][SW-1];
        end
    end

    assign sum       = r_p[STAGES-1];
    assign cout      = c_p[STAGES];
    assign ovf       = ovf_p;
    assign valid_out = vld_p[STAGES];

endmodule

// File: tb/tb_add_sub_np.sv
// Bench for add_sub_np: three instances (STAGES=4, 1, 32) share one stimulus
// stream, and each has its own scoreboard queue sized to its latency.
module tb_add_sub_np;

    localparam int W = 32;

    typedef struct packed {
        logic         v;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, ena, valid_in, sub, cin;
    logic [W-1:0] x, y;

    logic [W-1:0] s4, s1, s32;
    logic         c4, c1, c32, o4, o1, o32, v4, v1, v32;

    exp_t q4[$], q1[$], q32[$];
    exp_t l4, l1, l32;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    add_sub_np #(.WIDTH(W), .STAGES(4)) u_d4 (
        .clk(clk), .reset(reset), .ena(ena), .valid_in(valid_in), .sub(sub), .cin(cin),
        .x(x), .y(y), .sum(s4), .cout(c4), .ovf(o4), .valid_out(v4));

    add_sub_np #(.WIDTH(W), .STAGES(1)) u_d1 (
        .clk(clk), .reset(reset), .ena(ena), .valid_in(valid_in), .sub(sub), .cin(cin),
        .x(x), .y(y), .sum(s1), .cout(c1), .ovf(o1), .valid_out(v1));

    add_sub_np #(.WIDTH(W), .STAGES(32)) u_d32 (
        .clk(clk), .reset(reset), .ena(ena), .valid_in(valid_in), .sub(sub), .cin(cin),
        .x(x), .y(y), .sum(s32), .cout(c32), .ovf(o32), .valid_out(v32));

    function automatic exp_t mk(input logic v, input logic [W-1:0] s, input logic c, input logic o);
        exp_t e;
        e.v = v; e.s = s; e.c = c; e.o = o;
        return e;
    endfunction

    // Golden model: two's-complement add; overflow from operand/result signs
    function automatic exp_t calc(input logic v, input logic sb, input logic ci,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] bi;
        logic [W:0]   t;
        bi = sb ? ~b : b;
        t  = {1'b0, a} + {1'b0, bi} + {{W{1'b0}}, (sb ? ~ci : ci)};
        return mk(v, t[W-1:0], t[W], (a[W-1] == bi[W-1]) && (t[W-1] != a[W-1]));
    endfunction

    task automatic cmp(input string tag, input exp_t e, input logic [W-1:0] gs,
                       input logic gc, input logic go, input logic gv, input bit full);
        total++;
        assert (gv === e.v) else begin
            bad++;
            $error("FAIL %s valid_out got=%b exp=%b", tag, gv, e.v);
        end
        if (e.v || full) begin
            total++;
            assert ({gs, gc, go} === {e.s, e.c, e.o}) else begin
                bad++;
                $error("FAIL %s data got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                       tag, gs, gc, go, e.s, e.c, e.o);
            end
        end
    endtask

    task automatic check_all(input string tag, input bit full);
        cmp({tag, "/s4"},  l4,  s4,  c4,  o4,  v4,  full);
        cmp({tag, "/s1"},  l1,  s1,  c1,  o1,  v1,  full);
        cmp({tag, "/s32"}, l32, s32, c32, o32, v32, full);
    endtask

    // Reset leaves latency-1 zero bubbles between input and output
    task automatic init_queues();
        q4.delete(); q1.delete(); q32.delete();
        repeat (4)  q4.push_back('0);
        repeat (1)  q1.push_back('0);
        repeat (32) q32.push_back('0);
        l4 = '0; l1 = '0; l32 = '0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        l4 = '0; l1 = '0; l32 = '0;
        check_all(tag, 1'b1);
        init_queues();
        repeat (2) @(posedge clk);
        #1;
        check_all({tag, "_held"}, 1'b1);
        reset = 1'b1;
    endtask

    task automatic step_exp(input string tag, input logic v, input logic sb, input logic ci,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic en, input exp_t ex);
        valid_in = v; sub = sb; cin = ci; x = a; y = b; ena = en;
        @(posedge clk);
        #1;
        if (en) begin
            q4.push_back(ex);
            q1.push_back(ex);
            q32.push_back(ex);
            if (q4.size()  >= 5)  l4  = q4.pop_front();
            if (q1.size()  >= 2)  l1  = q1.pop_front();
            if (q32.size() >= 33) l32 = q32.pop_front();
        end
        check_all(tag, 1'b0);
    endtask

    task automatic step(input string tag, input logic v, input logic sb, input logic ci,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic en);
        step_exp(tag, v, sb, ci, a, b, en, calc(v, sb, ci, a, b));
    endtask

    task automatic flush();
        repeat (33) step("flush", 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; ena = 1'b0; valid_in = 1'b0; sub = 1'b0; cin = 1'b0;
        x = '0; y = '0;
        #2;
        do_reset("reset");

        // Directed corner cases with hand-derived results
        step_exp("ripple",   1, 0, 1, 32'hFFFF_FFFF, 32'h0000_0000, 1, mk(1, 32'h0000_0000, 1, 0));
        step_exp("sovf",     1, 0, 0, 32'h7FFF_FFFF, 32'h0000_0001, 1, mk(1, 32'h8000_0000, 0, 1));
        step_exp("sub_b0",   1, 1, 0, 32'd5,         32'd7,         1, mk(1, 32'hFFFF_FFFE, 0, 0));
        step_exp("sub_b1",   1, 1, 1, 32'd5,         32'd7,         1, mk(1, 32'hFFFF_FFFD, 0, 0));
        step_exp("sub_novf", 1, 1, 0, 32'h8000_0000, 32'd1,         1, mk(1, 32'h7FFF_FFFF, 1, 1));
        step_exp("sub_pos",  1, 1, 0, 32'd7,         32'd5,         1, mk(1, 32'h0000_0002, 1, 0));
        step_exp("gap",      0, 0, 0, 32'h1234_5678, 32'h1111_1111, 1, mk(0, 32'h2345_6789, 0, 0));
        step_exp("nadd",     1, 0, 0, 32'h8000_0000, 32'h8000_0000, 1, mk(1, 32'h0000_0000, 1, 1));

        // Enable stall with words in flight; stalled inputs must not be captured
        step("pre_stall", 1, 0, 0, 32'hA5A5_0001, 32'h0F0F_0F0F, 1);
        step("pre_stall", 1, 1, 1, 32'h0000_1000, 32'h0000_2000, 1);
        step("pre_stall", 1, 0, 1, 32'hDEAD_BEEF, 32'h2152_4110, 1);
        repeat (3) step("stall", 1, 1, 0, $urandom, $urandom, 0);
        flush();

        // Random back-to-back traffic with sporadic stalls and gaps
        for (int i = 0; i < 1000; i++) begin
            step("rand", ($urandom_range(0, 99) < 85), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom, $urandom, ($urandom_range(0, 9) != 0));
        end

        // Reset with words in flight, then only new words may emerge
        repeat (4) step("inflight", 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, 1);
        do_reset("midreset");
        for (int i = 0; i < 40; i++) begin
            step("post_rst", 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, 1);
        end
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_sub_np.md
Name: add_sub_np

Overview:
- Parametrised N-segment pipelined adder/subtractor. Successor to the fixed 22-bit, 3-segment pipelined adder.
- Splits WIDTH-bit operands into STAGES equal segments. Ripples carry one segment per clock, so the clock rate is set by a WIDTH/STAGES-bit add.
- Adds a subtract mode, carry/borrow-in, signed overflow, a valid tag and a global clock enable.
- Sits in DSP datapaths (accumulators, FIR/CIC adder trees) that need full throughput at high clock rates.

Parameters:
- WIDTH, 32, total operand/result bit width; must be an integer multiple of STAGES.
- STAGES, 4, number of carry-pipeline segments (1..WIDTH); segment width SW = WIDTH/STAGES.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- ena  in  1  clock enable; 0 freezes every pipeline register.
- valid_in  in  1  input word valid.
- sub  in  1  0: x + y + cin; 1: x - y - cin (cin acts as borrow-in).
- cin  in  1  carry-in (add mode) or borrow-in (sub mode).
- x  in  WIDTH  operand A, two's complement or unsigned.
- y  in  WIDTH  operand B.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. In sub mode, 1 = no borrow.
- ovf  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.
- valid_out  out  1  sum/cout/ovf correspond to a valid input.

Behaviour:
- Reset (reset=0, async): every pipeline register clears; sum=0, cout=0, ovf=0, valid_out=0. The pipeline is fully flushed. On release, valid_out stays 0 until a valid word has traversed the full latency.
- Stage 0 (input register), captured when ena=1:
  - x unchanged.
  - yi = sub ? ~y : y.
  - c0 = sub ? ~cin : cin.
  - valid and all operand segments captured.
- Stage k, k=1..STAGES:
  - Segment k-1 computes {c_k, r_k} = x_seg + yi_seg + c_(k-1), SW+1 bits.
  - Already-computed lower result segments are delayed one register.
  - Not-yet-added upper operand segments are delayed one register.
  - No combinational path spans more than one SW+1-bit add.
- Output: after stage STAGES:
  - sum = {r_STAGES..r_1}.
  - cout = c_STAGES.
  - ovf = c_STAGES XOR (carry into bit WIDTH-1), captured inside the last segment add.
- Latency: STAGES+1 enabled clock edges from input to output. Throughput is one word per enabled clock; back-to-back words never interact.
- Valid tag travels with the data through STAGES+1 registers. Data registers load regardless of valid_in; outputs for invalid slots are don't-care but deterministic.
- ena=0: all registers, including valid, hold their values; outputs stay stable. Latency counts enabled edges only.
- Reset asserted mid-operation discards all in-flight words immediately. No output word is partially updated.
- STAGES=1: degenerate case, an input register plus one full-width add (latency 2).
- STAGES=WIDTH: 1-bit segments, latency WIDTH+1.
- WIDTH not divisible by STAGES: elaboration-time error.
- Unsigned users read cout. Signed users read ovf. Both are always produced.

Test Plan (WIDTH=32, STAGES=4, latency 5):
- Full carry ripple: x=0xFFFFFFFF, y=0x00000000, cin=1, sub=0, valid_in=1 -> after 5 edges: sum=0x00000000, cout=1, ovf=0, valid_out=1.
- Signed overflow: x=0x7FFFFFFF, y=0x00000001, sub=0, cin=0 -> sum=0x80000000, cout=0, ovf=1.
- Subtract with borrow: x=5, y=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0. Same with cin=1 -> sum=0xFFFFFFFD.
- Back-to-back throughput: 1000 random valid words, one per clock, mixed sub/cin. Each output matches the golden model exactly 5 clocks later; valid_out pattern equals the delayed valid_in pattern.
- Enable stall: ena=0 for 3 clocks while 3 words are in flight -> outputs frozen. After ena returns to 1, words emerge in order with correct values, 5 enabled edges after entry.
- Mid-operation reset: reset=0 with 4 words in flight -> sum=0, cout=0, ovf=0, valid_out=0 immediately (no clock). After release, valid_out stays 0 for 5 edges; only new words appear. Re-run the random test at STAGES=1 (latency 2) and at STAGES=32 (latency 33).
